// File: rtl/fir_tap_sequencer_if.sv
// Handshake and datapath-control bundle between the FIR tap sequencer and
// its window register, coefficient ROM, MAC and downstream consumer.
interface fir_tap_sequencer_if #(
  parameter int GAIN_W = 4
);
  logic              sample_valid_i;
  logic              sample_ready_o;
  logic              shift_en_o;
  logic [7:0]        tap_addr_o;
  logic              mac_en_o;
  logic              mac_clr_o;
  logic [32:0]       mac_result_i;
  logic [GAIN_W-1:0] gain_i;
  logic [15:0]       out_data_o;
  logic              out_valid_o;
  logic              out_ready_i;
  logic              busy_o;
  logic              overrun_o;

  modport master (
    input  sample_valid_i, mac_result_i, gain_i, out_ready_i,
    output sample_ready_o, shift_en_o, tap_addr_o, mac_en_o, mac_clr_o,
           out_data_o, out_valid_o, busy_o, overrun_o
  );

  modport slave (
    output sample_valid_i, mac_result_i, gain_i, out_ready_i,
    input  sample_ready_o, shift_en_o, tap_addr_o, mac_en_o, mac_clr_o,
           out_data_o, out_valid_o, busy_o, overrun_o
  );
endinterface

// File: rtl/fir_tap_sequencer.sv
// FIR control FSM: per accepted sample, walk all taps through the MAC, drain
// the MAC pipeline, apply gain shift with saturation and hand off one word.
module fir_tap_sequencer #(
  parameter int NUM_TAPS = 10,
  parameter int MAC_LAT  = 2,
  parameter int GAIN_W   = 4
) (
  input logic                 clk,
  input logic                 reset,
  fir_tap_sequencer_if.master bus
);
  localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, CAPTURE, OUTPUT} state_t;

  state_t              state;
  logic [7:0]          tap_cnt;
  logic [DW-1:0]       drn_cnt;
  logic                accept;
  logic [GAIN_W-1:0]   gain;
  logic signed [32:0]  shifted;
  logic [15:0]         sat;

  // A new sample can enter on the same cycle the previous result is taken.
  assign bus.sample_ready_o = (state == IDLE) || ((state == OUTPUT) && bus.out_ready_i);
  assign accept             = bus.sample_valid_i && bus.sample_ready_o;
  assign bus.shift_en_o     = accept;
  assign bus.tap_addr_o     = tap_cnt;

  assign gain    = bus.gain_i;
  assign shifted = $signed(bus.mac_result_i) >>> gain;

  always_comb begin
    sat = shifted[15:0];
    if (shifted > 33'sd32767)       sat = 16'h7FFF;
    else if (shifted < -33'sd32768) sat = 16'h8000;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      tap_cnt         <= '0;
      drn_cnt         <= '0;
      bus.mac_en_o    <= 1'b0;
      bus.mac_clr_o   <= 1'b0;
      bus.out_valid_o <= 1'b0;
      bus.out_data_o  <= '0;
      bus.busy_o      <= 1'b0;
      bus.overrun_o   <= 1'b0;
    end else begin
      // Dropped samples never disturb the running computation.
      if (bus.sample_valid_i && !bus.sample_ready_o) bus.overrun_o <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            state         <= ISSUE;
            tap_cnt       <= '0;
            bus.mac_en_o  <= 1'b1;
            bus.mac_clr_o <= 1'b1;
            bus.busy_o    <= 1'b1;
          end
        end
        ISSUE: begin
          bus.mac_clr_o <= 1'b0;
          if (tap_cnt == 8'(NUM_TAPS - 1)) begin
            state        <= DRAIN;
            tap_cnt      <= '0;
            bus.mac_en_o <= 1'b0;
            drn_cnt      <= DW'(MAC_LAT - 1);
          end else begin
            tap_cnt <= tap_cnt + 8'd1;
          end
        end
        DRAIN: begin
          if (drn_cnt == '0) state <= CAPTURE;
          else               drn_cnt <= drn_cnt - DW'(1);
        end
        CAPTURE: begin
          bus.out_data_o  <= sat;
          bus.out_valid_o <= 1'b1;
          state           <= OUTPUT;
        end
        OUTPUT: begin
          if (bus.out_ready_i) begin
            bus.out_valid_o <= 1'b0;
            if (accept) begin
              state         <= ISSUE;
              tap_cnt       <= '0;
              bus.mac_en_o  <= 1'b1;
              bus.mac_clr_o <= 1'b1;
            end else begin
              state      <= IDLE;
              bus.busy_o <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer: models window/ROM/MAC around the DUT and checks
// results against a direct dot-product + shift + clamp reference.
module tb_fir_tap_sequencer;
  localparam int NUM_TAPS = 10;
  localparam int MAC_LAT  = 2;
  localparam int GAIN_W   = 4;
  localparam int OUT_LAT  = NUM_TAPS + MAC_LAT + 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fir_tap_sequencer_if #(.GAIN_W(GAIN_W)) bus();

  fir_tap_sequencer #(.NUM_TAPS(NUM_TAPS), .MAC_LAT(MAC_LAT), .GAIN_W(GAIN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Surrounding datapath: window register, coefficient ROM, 2-cycle MAC.
  logic signed [15:0] coef    [NUM_TAPS];
  logic signed [15:0] win     [NUM_TAPS];
  logic signed [15:0] ref_win [NUM_TAPS];
  logic signed [15:0] adc_sample = '0;
  logic signed [15:0] pre_val = '0;
  logic               preload = 1'b0;
  logic signed [31:0] pd;
  logic               pe, pc;
  logic signed [32:0] acc;
  logic               force_en = 1'b0;
  logic [32:0]        force_val = '0;
  int                 ta;

  assign bus.mac_result_i = force_en ? force_val : acc;
  assign ta = int'(bus.tap_addr_o) % NUM_TAPS;

  always @(posedge clk) begin
    if (reset) begin
      pe <= 1'b0; pc <= 1'b0; pd <= '0; acc <= '0;
      for (int i = 0; i < NUM_TAPS; i++) win[i] <= '0;
    end else begin
      if (preload) begin
        for (int i = 0; i < NUM_TAPS; i++) win[i] <= pre_val;
      end else if (bus.shift_en_o) begin
        win[0] <= adc_sample;
        for (int i = 1; i < NUM_TAPS; i++) win[i] <= win[i-1];
      end
      pe <= bus.mac_en_o;
      pc <= bus.mac_clr_o;
      pd <= coef[ta] * win[ta];
      if (pe) acc <= pc ? {pd[31], pd} : acc + {pd[31], pd};
    end
  end

  function automatic logic [15:0] ref_sat(input longint v, input int g);
    longint r;
    r = v >>> g;
    if (r > 32767)  return 16'h7FFF;
    if (r < -32768) return 16'h8000;
    return 16'(r);
  endfunction

  function automatic logic [15:0] ref_out(input int g);
    longint s = 0;
    for (int k = 0; k < NUM_TAPS; k++) s += longint'(coef[k]) * longint'(ref_win[k]);
    return ref_sat(s, g);
  endfunction

  task automatic push_ref(input logic signed [15:0] s);
    for (int k = NUM_TAPS - 1; k > 0; k--) ref_win[k] = ref_win[k-1];
    ref_win[0] = s;
  endtask

  // Offer one sample from IDLE and wait (bounded) for out_valid_o.
  task automatic send_and_wait(input logic signed [15:0] s, output logic took, output int lat);
    @(negedge clk);
    bus.sample_valid_i = 1'b1;
    adc_sample = s;
    #1;
    took = bus.shift_en_o;
    if (took) push_ref(s);
    @(negedge clk);
    bus.sample_valid_i = 1'b0;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      #1;
      if (bus.out_valid_o) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_handshake();
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    bus.out_ready_i = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic [36:0] got;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    got = {bus.sample_ready_o, bus.shift_en_o, bus.mac_en_o, bus.mac_clr_o, bus.busy_o,
           bus.out_valid_o, bus.overrun_o, bus.tap_addr_o, bus.out_data_o, 6'd0};
    n_cmp++;
    if (got !== {1'b1, 6'd0, 8'd0, 16'd0, 6'd0}) begin
      n_err++; $display("FAIL reset_init: got %h want %h", got, {1'b1, 36'd0});
    end
    // start a sample, provoke an overrun mid-ISSUE, then reset
    @(negedge clk); bus.sample_valid_i = 1'b1; adc_sample = 16'sh0042;
    @(negedge clk); bus.sample_valid_i = 1'b0;
    @(negedge clk); bus.sample_valid_i = 1'b1;
    @(negedge clk); bus.sample_valid_i = 1'b0;
    #1;
    n_cmp++;
    if ({bus.busy_o, bus.mac_en_o, bus.overrun_o} !== 3'b111) begin
      n_err++; $display("FAIL reset_pre_issue: got %b want 111", {bus.busy_o, bus.mac_en_o, bus.overrun_o});
    end
    reset = 1'b1;
    for (int k = 0; k < NUM_TAPS; k++) ref_win[k] = '0;
    @(negedge clk); #1;
    n_cmp++;
    if ({bus.sample_ready_o, bus.busy_o, bus.mac_en_o, bus.out_valid_o, bus.overrun_o} !== 5'b10000) begin
      n_err++; $display("FAIL reset_first_edge: got %b want 10000",
                        {bus.sample_ready_o, bus.busy_o, bus.mac_en_o, bus.out_valid_o, bus.overrun_o});
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #1;
    n_cmp++;
    if ({bus.sample_ready_o, bus.busy_o, bus.mac_en_o, bus.out_valid_o, bus.overrun_o, bus.tap_addr_o}
        !== {5'b10000, 8'd0}) begin
      n_err++; $display("FAIL reset_release: got %b want 1000000000000",
                        {bus.sample_ready_o, bus.busy_o, bus.mac_en_o, bus.out_valid_o, bus.overrun_o, bus.tap_addr_o});
    end
  endtask

  task automatic test_basic();
    logic [11:0] got, exp;
    for (int k = 0; k < NUM_TAPS; k++) begin coef[k] = 16'sd1; ref_win[k] = 16'sh0100; end
    @(negedge clk); preload = 1'b1; pre_val = 16'sh0100;
    @(negedge clk); preload = 1'b0;
    bus.sample_valid_i = 1'b1; adc_sample = 16'sh0100;
    #1;
    n_cmp++;
    if ({bus.shift_en_o, bus.sample_ready_o} !== 2'b11) begin
      n_err++; $display("FAIL basic_accept: got %b want 11", {bus.shift_en_o, bus.sample_ready_o});
    end
    push_ref(16'sh0100);
    @(negedge clk); bus.sample_valid_i = 1'b0;
    for (int k = 1; k <= OUT_LAT; k++) begin
      #1;
      exp = {1'b0, 1'(k <= NUM_TAPS), 1'(k == 1), (k <= NUM_TAPS) ? 8'(k - 1) : 8'd0, 1'(k == OUT_LAT)};
      got = {bus.shift_en_o, bus.mac_en_o, bus.mac_clr_o, bus.tap_addr_o, bus.out_valid_o};
      n_cmp++;
      if (got !== exp) begin
        n_err++; $display("FAIL basic_cycle%0d: got %h want %h", k, got, exp);
      end
      if (k < OUT_LAT) @(negedge clk);
    end
    n_cmp++;
    if (bus.out_data_o !== 16'h0A00) begin
      n_err++; $display("FAIL basic_data: got %h want 0a00", bus.out_data_o);
    end
    do_handshake();
  endtask

  task automatic test_gain();
    logic took; int lat;
    int gains [2] = '{4, 15};
    logic [15:0] want [2] = '{16'h00A0, 16'h0000};
    for (int i = 0; i < 2; i++) begin
      bus.gain_i = GAIN_W'(gains[i]);
      send_and_wait(16'sh0100, took, lat);
      n_cmp++;
      if (!took || lat != OUT_LAT || bus.out_data_o !== want[i] || ref_out(gains[i]) !== want[i]) begin
        n_err++; $display("FAIL gain%0d: took %b lat %0d data %h want lat %0d data %h",
                          gains[i], took, lat, bus.out_data_o, OUT_LAT, want[i]);
      end
      do_handshake();
    end
    bus.gain_i = '0;
  endtask

  task automatic test_saturation();
    logic took; int lat;
    logic [32:0] vals [3] = '{33'h0_0010_0000, 33'h1_FFF0_0000, 33'h0_0010_0000};
    int gains [3] = '{0, 0, 8};
    logic [15:0] want [3] = '{16'h7FFF, 16'h8000, 16'h1000};
    force_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      force_val = vals[i];
      bus.gain_i = GAIN_W'(gains[i]);
      send_and_wait(16'sh0001, took, lat);
      n_cmp++;
      if (lat != OUT_LAT || bus.out_data_o !== want[i] ||
          ref_sat(longint'($signed(vals[i])), gains[i]) !== want[i]) begin
        n_err++; $display("FAIL sat%0d: lat %0d data %h want %h", i, lat, bus.out_data_o, want[i]);
      end
      do_handshake();
    end
    force_en = 1'b0;
    bus.gain_i = '0;
  endtask

  task automatic test_random();
    logic took; int lat, g;
    logic [15:0] want;
    for (int it = 0; it < 8; it++) begin
      for (int k = 0; k < NUM_TAPS; k++) coef[k] = 16'($signed($urandom_range(0, 511)) - 256);
      g = $urandom_range(0, 6);
      bus.gain_i = GAIN_W'(g);
      send_and_wait(16'($signed($urandom_range(0, 8191)) - 4096), took, lat);
      want = ref_out(g);
      n_cmp++;
      if (!took || lat != OUT_LAT || bus.out_data_o !== want) begin
        n_err++; $display("FAIL random%0d: took %b lat %0d data %h want %h", it, took, lat, bus.out_data_o, want);
      end
      do_handshake();
    end
  endtask

  task automatic test_backpressure();
    logic took; int lat;
    logic [15:0] want;
    bus.gain_i = GAIN_W'(2);
    send_and_wait(16'sh0123, took, lat);
    want = ref_out(2);
    n_cmp++;
    if (lat != OUT_LAT || bus.out_data_o !== want) begin
      n_err++; $display("FAIL bp_first: lat %0d data %h want %h", lat, bus.out_data_o, want);
    end
    for (int i = 0; i < 5; i++) begin
      bus.sample_valid_i = (i == 2);
      adc_sample = 16'sh7777;
      #1;
      n_cmp++;
      if ({bus.out_valid_o, bus.sample_ready_o, bus.shift_en_o} !== 3'b100 || bus.out_data_o !== want) begin
        n_err++; $display("FAIL bp_stall%0d: vld/rdy/shift %b data %h want 100 %h",
                          i, {bus.out_valid_o, bus.sample_ready_o, bus.shift_en_o}, bus.out_data_o, want);
      end
      @(negedge clk);
    end
    bus.sample_valid_i = 1'b0;
    #1;
    n_cmp++;
    if (bus.overrun_o !== 1'b1) begin
      n_err++; $display("FAIL bp_overrun: got %b want 1", bus.overrun_o);
    end
    do_handshake();
    n_cmp++;
    if ({bus.out_valid_o, bus.busy_o, bus.overrun_o} !== 3'b001 || bus.out_data_o !== want) begin
      n_err++; $display("FAIL bp_after: vld/busy/ovr %b data %h want 001 %h",
                        {bus.out_valid_o, bus.busy_o, bus.overrun_o}, bus.out_data_o, want);
    end
  endtask

  task automatic test_back_to_back();
    logic took; int lat;
    logic [15:0] want;
    logic ovr;
    bus.gain_i = GAIN_W'(1);
    send_and_wait(16'sh0400, took, lat);
    want = ref_out(1);
    n_cmp++;
    if (lat != OUT_LAT || bus.out_data_o !== want) begin
      n_err++; $display("FAIL b2b_first: lat %0d data %h want %h", lat, bus.out_data_o, want);
    end
    ovr = bus.overrun_o;
    bus.out_ready_i = 1'b1;
    bus.sample_valid_i = 1'b1;
    adc_sample = -16'sd300;
    #1;
    n_cmp++;
    if ({bus.sample_ready_o, bus.shift_en_o} !== 2'b11) begin
      n_err++; $display("FAIL b2b_accept: got %b want 11", {bus.sample_ready_o, bus.shift_en_o});
    end
    push_ref(-16'sd300);
    @(negedge clk);
    bus.out_ready_i = 1'b0;
    bus.sample_valid_i = 1'b0;
    #1;
    n_cmp++;
    if ({bus.busy_o, bus.tap_addr_o, bus.mac_en_o, bus.mac_clr_o, bus.out_valid_o, bus.overrun_o}
        !== {1'b1, 8'd0, 1'b1, 1'b1, 1'b0, ovr}) begin
      n_err++; $display("FAIL b2b_issue: got %b want %b",
                        {bus.busy_o, bus.tap_addr_o, bus.mac_en_o, bus.mac_clr_o, bus.out_valid_o, bus.overrun_o},
                        {1'b1, 8'd0, 1'b1, 1'b1, 1'b0, ovr});
    end
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      if (k > 1) begin @(negedge clk); #1; end
      if (bus.out_valid_o) begin lat = k; break; end
    end
    want = ref_out(1);
    n_cmp++;
    if (lat != OUT_LAT || bus.out_data_o !== want) begin
      n_err++; $display("FAIL b2b_second: lat %0d data %h want lat %0d data %h", lat, bus.out_data_o, OUT_LAT, want);
    end
    do_handshake();
  endtask

  initial begin
    bus.sample_valid_i = 1'b0;
    bus.out_ready_i = 1'b0;
    bus.gain_i = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin coef[k] = '0; ref_win[k] = '0; end
    test_reset();
    test_basic();
    test_gain();
    test_saturation();
    test_random();
    test_backpressure();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end
endmodule
